// File: rtl/nn_accumulator.sv
// nn_accumulator
//   Consumer end of the product stream. For every output node w it sums the
//   per-weight ciphertext products over all DEPTH input nodes of one column k
//   and emits one accumulated ciphertext per (k, w) on a valid/ready stream.
//   Each 36-bit word carries two independent 18-bit lanes that wrap mod 2^18.
//
// Ports
//   clk_in     system clock
//   rst_in     asynchronous active-low reset
//   sum_valid  product beat valid            sum_ready  beat can be accepted
//   sum_in     product {lane B, lane A}      sum_idx_k  ciphertext column
//   sum_idx_N  input-node index              sum_idx_w  output-node index
//   acc_valid  result valid                  acc_ready  downstream accepts
//   acc_out    accumulated ciphertext        acc_idx_k  column of acc_out
//   acc_idx_w  output node of acc_out        row_done   pulse after last w
//   proto_err  sticky protocol-error flag
module nn_accumulator #(
  parameter int K_VAL     = 501,
  parameter int DEPTH     = 100,
  parameter int OUT_NODES = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        sum_valid,
  output logic        sum_ready,
  input  logic [35:0] sum_in,
  input  logic [9:0]  sum_idx_k,
  input  logic [9:0]  sum_idx_N,
  input  logic [5:0]  sum_idx_w,
  output logic        acc_valid,
  input  logic        acc_ready,
  output logic [35:0] acc_out,
  output logic [9:0]  acc_idx_k,
  output logic [5:0]  acc_idx_w,
  output logic        row_done,
  output logic        proto_err
);

  localparam int         WORD_W = 36;
  localparam logic [9:0] N_LAST = 10'(DEPTH - 1);
  localparam logic [5:0] W_LAST = 6'(OUT_NODES - 1);
  localparam logic [6:0] W_LIM  = 7'(OUT_NODES);
  localparam logic [10:0] K_LIM = 11'(K_VAL);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                        state_reg;
  logic [9:0]                    cur_k_reg;
  logic                          acc_valid_reg;
  logic [35:0]                   acc_out_reg;
  logic [9:0]                    acc_idx_k_reg;
  logic [5:0]                    acc_idx_w_reg;
  logic                          row_done_reg;
  logic                          proto_err_reg;
  logic [OUT_NODES*WORD_W-1:0]   bank_reg;
  logic [OUT_NODES*WORD_W-1:0]   bank_next;

  logic        accept;
  logic        w_ok;
  logic        k_ok;
  logic        is_first_n;
  logic        is_last_n;
  logic        is_start;
  logic        is_row_end;
  logic        load_result;
  logic        err_now;
  logic [35:0] bank_rd;
  logic [35:0] sum_new;

  // The output register frees up on the same edge it is popped, so a new
  // beat may be taken whenever the held result is leaving or absent.
  assign sum_ready   = ~acc_valid_reg | acc_ready;
  assign accept      = sum_valid & sum_ready;
  assign w_ok        = {1'b0, sum_idx_w} < W_LIM;
  assign k_ok        = {1'b0, sum_idx_k} < K_LIM;
  assign is_first_n  = (sum_idx_N == 10'd0);
  assign is_last_n   = (sum_idx_N == N_LAST);
  assign is_start    = is_first_n && (sum_idx_w == 6'd0);
  assign is_row_end  = is_last_n && (sum_idx_w == W_LAST);
  assign load_result = accept && w_ok && is_last_n;

  // Explicit select keeps the read in range for any 6-bit w.
  always_comb begin
    bank_rd = '0;
    for (int i = 0; i < OUT_NODES; i++) begin
      if (sum_idx_w == 6'(i)) bank_rd = bank_reg[i*WORD_W +: WORD_W];
    end
  end

  // Lane-wise add: each 18-bit sum truncates, so no carry crosses lanes.
  always_comb begin
    if (is_first_n) begin
      sum_new = sum_in;
    end else begin
      sum_new[17:0]  = bank_rd[17:0]  + sum_in[17:0];
      sum_new[35:18] = bank_rd[35:18] + sum_in[35:18];
    end
  end

  // A finishing beat empties its entry so the next column starts clean.
  generate
    for (genvar gi = 0; gi < OUT_NODES; gi++) begin : g_bank
      assign bank_next[gi*WORD_W +: WORD_W] =
        (accept && w_ok && (sum_idx_w == 6'(gi))) ?
          (is_last_n ? '0 : sum_new) : bank_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_comb begin
    err_now = 1'b0;
    if (accept) begin
      if (!w_ok || !k_ok) err_now = 1'b1;
      if (state_reg == IDLE && !is_start) err_now = 1'b1;
      if (state_reg == ACTIVE && (is_start || sum_idx_k != cur_k_reg)) err_now = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= IDLE;
      cur_k_reg     <= '0;
      acc_valid_reg <= 1'b0;
      acc_out_reg   <= '0;
      acc_idx_k_reg <= '0;
      acc_idx_w_reg <= '0;
      row_done_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
      bank_reg      <= '0;
    end else begin
      bank_reg     <= bank_next;
      row_done_reg <= 1'b0;
      if (err_now) proto_err_reg <= 1'b1;

      if (accept) begin
        unique case (state_reg)
          IDLE: begin
            if (is_start) begin
              cur_k_reg <= sum_idx_k;
              // A 1x1 row starts and ends on the same beat.
              if (is_row_end) row_done_reg <= 1'b1;
              else            state_reg    <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (is_start) begin
              cur_k_reg <= sum_idx_k;
            end else if (is_row_end) begin
              row_done_reg <= 1'b1;
              state_reg    <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end

      if (load_result) begin
        acc_valid_reg <= 1'b1;
        acc_out_reg   <= sum_new;
        acc_idx_k_reg <= sum_idx_k;
        acc_idx_w_reg <= sum_idx_w;
      end else if (acc_ready) begin
        acc_valid_reg <= 1'b0;
      end
    end
  end

  assign acc_valid = acc_valid_reg;
  assign acc_out   = acc_out_reg;
  assign acc_idx_k = acc_idx_k_reg;
  assign acc_idx_w = acc_idx_w_reg;
  assign row_done  = row_done_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_nn_accumulator.sv
// Directed bench for nn_accumulator with DEPTH=3, OUT_NODES=2.
module tb_nn_accumulator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sum_valid;
  logic        sum_ready;
  logic [35:0] sum_in;
  logic [9:0]  sum_idx_k;
  logic [9:0]  sum_idx_N;
  logic [5:0]  sum_idx_w;
  logic        acc_valid;
  logic        acc_ready;
  logic [35:0] acc_out;
  logic [9:0]  acc_idx_k;
  logic [5:0]  acc_idx_w;
  logic        row_done;
  logic        proto_err;

  int compared   = 0;
  int mismatched = 0;
  int pops       = 0;

  nn_accumulator #(.K_VAL(501), .DEPTH(3), .OUT_NODES(2)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_in    (sum_in),
    .sum_idx_k (sum_idx_k),
    .sum_idx_N (sum_idx_N),
    .sum_idx_w (sum_idx_w),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_out   (acc_out),
    .acc_idx_k (acc_idx_k),
    .acc_idx_w (acc_idx_w),
    .row_done  (row_done),
    .proto_err (proto_err)
  );

  always #5 clk_in = ~clk_in;

  // Count every result handshake so drops or duplicates show up in the total.
  always @(posedge clk_in) begin
    if (rst_in && acc_valid && acc_ready) pops = pops + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send(input logic [9:0] n, input logic [5:0] w, input logic [9:0] k,
                      input logic [35:0] d);
    logic ok;
    logic got;
    got       = 1'b0;
    sum_valid = 1'b1;
    sum_idx_N = n;
    sum_idx_w = w;
    sum_idx_k = k;
    sum_in    = d;
    for (int c = 0; c < 20 && !got; c++) begin
      ok = sum_ready;
      @(posedge clk_in);
      #1;
      if (ok) got = 1'b1;
    end
    sum_valid = 1'b0;
    check("beat_accepted", got, 1'b1);
    $display("beat N=%0d w=%0d k=%0d data=%09h acc_valid=%0d acc_out=%09h", n, w, k, d,
             acc_valid, acc_out);
  endtask

  task automatic idle_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_in = 1'b0;
    #2 rst_in = 1'b1;
  endtask

  initial begin
    rst_in    = 1'b0;
    sum_valid = 1'b0;
    sum_in    = '0;
    sum_idx_k = '0;
    sum_idx_N = '0;
    sum_idx_w = '0;
    acc_ready = 1'b1;

    // Reset state
    #12;
    check("rst_acc_valid", acc_valid, 1'b0);
    check("rst_acc_out", acc_out, 36'h0);
    check("rst_row_done", row_done, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    rst_in = 1'b1;
    #1;
    check("rst_sum_ready", sum_ready, 1'b1);

    // Basic row, k=5, w-major order
    send(10'd0, 6'd0, 10'd5, 36'd1);
    send(10'd1, 6'd0, 10'd5, 36'd2);
    send(10'd2, 6'd0, 10'd5, 36'd3);
    check("r1_w0_valid", acc_valid, 1'b1);
    check("r1_w0_out", acc_out, 36'd6);
    check("r1_w0_k", acc_idx_k, 10'd5);
    check("r1_w0_w", acc_idx_w, 6'd0);
    send(10'd0, 6'd1, 10'd5, 36'd10);
    check("r1_popped", acc_valid, 1'b0);
    send(10'd1, 6'd1, 10'd5, 36'd20);
    check("r1_no_early_done", row_done, 1'b0);
    send(10'd2, 6'd1, 10'd5, 36'd30);
    check("r1_w1_out", acc_out, 36'd60);
    check("r1_w1_k", acc_idx_k, 10'd5);
    check("r1_w1_w", acc_idx_w, 6'd1);
    check("r1_row_done", row_done, 1'b1);
    check("r1_proto_err", proto_err, 1'b0);
    idle_cycle();
    check("r1_row_done_pulse", row_done, 1'b0);
    check("r1_idle_valid", acc_valid, 1'b0);

    // Lane wrap: A 0x3FFFF+0x2 -> 0x1, B 0x20000+0x20000 -> 0x0
    send(10'd0, 6'd0, 10'd5, {18'h20000, 18'h3FFFF});
    send(10'd1, 6'd0, 10'd5, {18'h20000, 18'h00002});
    send(10'd2, 6'd0, 10'd5, 36'h0);
    check("wrap_out", acc_out, 36'h000000001);
    send(10'd0, 6'd1, 10'd5, 36'h0);
    send(10'd1, 6'd1, 10'd5, 36'h0);
    send(10'd2, 6'd1, 10'd5, 36'h0);
    check("wrap_w1_out", acc_out, 36'h0);
    check("wrap_proto_err", proto_err, 1'b0);
    idle_cycle();

    // Backpressure with interleaved order so both finals are adjacent
    send(10'd0, 6'd0, 10'd7, 36'd4);
    send(10'd0, 6'd1, 10'd7, 36'd100);
    send(10'd1, 6'd0, 10'd7, 36'd5);
    send(10'd1, 6'd1, 10'd7, 36'd200);
    send(10'd2, 6'd0, 10'd7, 36'd6);
    acc_ready = 1'b0;
    #1;
    check("bp_sum_ready_low", sum_ready, 1'b0);
    sum_valid = 1'b1;
    sum_idx_N = 10'd2;
    sum_idx_w = 6'd1;
    sum_idx_k = 10'd7;
    sum_in    = 36'd300;
    for (int c = 0; c < 5; c++) begin
      idle_cycle();
      check("bp_hold_valid", acc_valid, 1'b1);
      check("bp_hold_out", acc_out, 36'd15);
      check("bp_hold_w", acc_idx_w, 6'd0);
      check("bp_hold_k", acc_idx_k, 10'd7);
      $display("stall cycle %0d acc_out=%0d sum_ready=%0d", c, acc_out, sum_ready);
    end
    acc_ready = 1'b1;
    #1;
    check("bp_sum_ready_high", sum_ready, 1'b1);
    idle_cycle();
    sum_valid = 1'b0;
    check("bp_pop_load_valid", acc_valid, 1'b1);
    check("bp_pop_load_out", acc_out, 36'd600);
    check("bp_pop_load_w", acc_idx_w, 6'd1);
    check("bp_row_done", row_done, 1'b1);
    idle_cycle();
    check("bp_drained", acc_valid, 1'b0);
    check("bp_pop_count", 36'(pops), 36'd6);

    // Out-of-range w mid-row: error flagged, bank untouched
    pulse_reset();
    send(10'd0, 6'd0, 10'd5, 36'd1);
    check("oor_no_err_yet", proto_err, 1'b0);
    send(10'd0, 6'd7, 10'd5, 36'd99);
    check("oor_proto_err", proto_err, 1'b1);
    check("oor_no_result", acc_valid, 1'b0);
    send(10'd1, 6'd0, 10'd5, 36'd2);
    send(10'd2, 6'd0, 10'd5, 36'd3);
    check("oor_bank_intact", acc_out, 36'd6);
    send(10'd0, 6'd1, 10'd5, 36'd10);
    send(10'd1, 6'd1, 10'd5, 36'd20);
    send(10'd2, 6'd1, 10'd5, 36'd30);
    check("oor_w1_out", acc_out, 36'd60);
    check("oor_sticky", proto_err, 1'b1);
    idle_cycle();

    // Non-start first beat in IDLE
    pulse_reset();
    check("idle_err_cleared", proto_err, 1'b0);
    send(10'd1, 6'd0, 10'd5, 36'd2);
    check("idle_bad_start_err", proto_err, 1'b1);

    // Column mismatch mid-row
    pulse_reset();
    send(10'd0, 6'd0, 10'd5, 36'd1);
    check("kmis_no_err_yet", proto_err, 1'b0);
    send(10'd1, 6'd0, 10'd6, 36'd2);
    check("kmis_proto_err", proto_err, 1'b1);
    send(10'd2, 6'd0, 10'd5, 36'd3);
    check("kmis_out", acc_out, 36'd6);
    check("kmis_k", acc_idx_k, 10'd5);

    // Async reset mid-row, between edges
    send(10'd0, 6'd0, 10'd5, 36'd1);
    send(10'd1, 6'd0, 10'd5, 36'd2);
    #2 rst_in = 1'b0;
    #1;
    check("arst_acc_out", acc_out, 36'h0);
    check("arst_acc_k", acc_idx_k, 10'd0);
    check("arst_proto_err", proto_err, 1'b0);
    check("arst_acc_valid", acc_valid, 1'b0);
    idle_cycle();
    rst_in = 1'b1;
    send(10'd0, 6'd0, 10'd5, 36'd1);
    send(10'd1, 6'd0, 10'd5, 36'd2);
    send(10'd2, 6'd0, 10'd5, 36'd3);
    check("arst_w0_out", acc_out, 36'd6);
    send(10'd0, 6'd1, 10'd5, 36'd10);
    send(10'd1, 6'd1, 10'd5, 36'd20);
    send(10'd2, 6'd1, 10'd5, 36'd30);
    check("arst_w1_out", acc_out, 36'd60);
    check("arst_row_done", row_done, 1'b1);
    check("arst_clean_err", proto_err, 1'b0);
    idle_cycle();
    check("total_pops", 36'(pops), 36'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nn_accumulator.md
Name: nn_accumulator

Overview:
- Consumer end of the nn_adder product stream (sum_valid/sum_ready handshake).
- Sums the per-weight ciphertext products over all DEPTH input nodes for each output node w, giving one accumulated ciphertext per (k, w).
- Emits each accumulated ciphertext on a valid/ready stream toward result memory or the decryptor.
- Each 36-bit word holds two independent 18-bit lanes.

Parameters:
- K_VAL, 501: ciphertext columns; sets the range of idx_k.
- DEPTH, 100: input nodes summed per output; idx_N runs 0..DEPTH-1.
- OUT_NODES, 10: output nodes; idx_w runs 0..OUT_NODES-1.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- sum_valid  in  1  product beat valid
- sum_ready  out  1  accumulator can accept a beat
- sum_in  in  36  product; [35:18] lane B, [17:0] lane A
- sum_idx_k  in  10  ciphertext column
- sum_idx_N  in  10  input-node index
- sum_idx_w  in  6  output-node index
- acc_valid  out  1  accumulated result valid
- acc_ready  in  1  downstream accepts result
- acc_out  out  36  accumulated ciphertext, same lane packing as sum_in
- acc_idx_k  out  10  column of acc_out
- acc_idx_w  out  6  output node of acc_out
- row_done  out  1  one-cycle pulse when the last w of a column completes
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_in low, async): acc_valid=0, acc_out=0, acc_idx_k=0, acc_idx_w=0, row_done=0, proto_err=0, all bank entries=0, cur_k=0, state=IDLE. sum_ready is high from the first cycle after reset releases.
- Reset mid-row discards every partial sum. No beat is emitted afterward for that row.
- sum_ready = ~acc_valid | acc_ready (combinational). A beat is accepted on a cycle with sum_valid & sum_ready.
- Storage: bank of OUT_NODES entries, each 36 bits, indexed by w.
- On an accepted beat with w = sum_idx_w < OUT_NODES:
  - new = sum_in if sum_idx_N==0; otherwise new = bank[w] + sum_in, computed per 18-bit lane.
  - Lane arithmetic wraps modulo 2^18. There is no carry between lanes.
  - If sum_idx_N==DEPTH-1: on the next edge load acc_out=new, acc_idx_k=sum_idx_k, acc_idx_w=w, acc_valid=1, and clear bank[w] to 0.
  - Otherwise: bank[w]=new.
- Latency: final beat accepted at edge t gives acc_valid high after edge t. One result per cycle is sustained while acc_ready stays high.
- acc_valid falls after an edge with acc_valid & acc_ready, unless a new final beat loads on that same edge; then it stays high with the new data.
- acc_out and the acc_idx outputs hold stable while acc_valid & ~acc_ready.
- Out-of-range beat (sum_idx_w >= OUT_NODES): the beat is consumed, the bank is unchanged, proto_err is set.
- FSM IDLE:
  - Accepted beat with N==0 and w==0: latch cur_k=sum_idx_k, go to ACTIVE.
  - Any other accepted beat: proto_err=1, beat still processed per the rules above, stay in IDLE.
- FSM ACTIVE:
  - Accepted beat with sum_idx_k != cur_k: proto_err=1, beat still processed.
  - Accepted beat with N==DEPTH-1 and w==OUT_NODES-1: row_done pulses high for exactly the cycle after the edge, go to IDLE.
  - A N==0, w==0 beat while ACTIVE: proto_err=1, cur_k reloaded, stay in ACTIVE.
- proto_err is cleared only by reset.
- Simultaneous events: an output pop and a final-beat load on the same edge are legal and produce no bubble. A beat is never lost while acc_valid is high, because sum_ready gates acceptance.

Test Plan:
- DEPTH=3, OUT_NODES=2, acc_ready=1, column k=5, beats in (N,w) order:
  - lane A products for w=0: 1, 2, 3; for w=1: 10, 20, 30; lane B = 0.
  - Expect acc_out 6 then 60, with acc_idx_k=5 and acc_idx_w 0 then 1.
  - Expect row_done high for one cycle after the (2,1) beat; proto_err=0.
- Lane wrap: lane A products 0x3FFFF and 0x00002, lane B products 0x20000 and 0x20000.
  - Expect lane A = 0x00001 and lane B = 0x00000 (no cross-lane carry).
- Backpressure: acc_ready=0 after the first result.
  - sum_ready drops; acc_out/acc_idx hold for 5 cycles.
  - Raise acc_ready: the next final beat loads on the pop edge; no beat dropped or duplicated.
- Errors:
  - Beat with sum_idx_w=7 (OUT_NODES=2): proto_err=1, bank unchanged.
  - Separate run: first beat (N=1, w=0) in IDLE gives proto_err=1.
  - Mid-row sum_idx_k=6 while cur_k=5 gives proto_err=1.
- Async reset: pull rst_in low mid-row (after N=1) between clock edges.
  - Outputs go to their reset values immediately.
  - Restart column k=5 from (0,0): results equal a clean run with no residue.
